// File: rtl/pvf_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pvf_pkg : shared types, widths and helpers for packet_verdict_filter        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
package pvf_pkg;

  typedef enum logic [0:0] {
    ACCEPT  = 1'b0,
    DISCARD = 1'b1
  } pvf_state_e;

  localparam int STAT_WIDTH = 32;

  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == {STAT_WIDTH{1'b1}}) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pvf_sdp_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | pvf_sdp_ram : simple dual-port RAM, one write port, one registered read     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module pvf_sdp_ram #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_BITS = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  we_i,
  input  logic [DEPTH_BITS-1:0] waddr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_BITS-1:0] raddr_i,
  output logic [WIDTH-1:0]      rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(1<<DEPTH_BITS)-1];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read register doubles as the downstream output stage, so it resets to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/packet_verdict_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | packet_verdict_filter : buffers whole packets, releases only clean ones.    |
// | Statistics counters built only when PKT_VERDICT_STATS_EN is defined.        |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module packet_verdict_filter
  import pvf_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int DEPTH_BITS         = 6
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tlast,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tdrop,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,

  output logic [STAT_WIDTH-1:0]           pass_count,
  output logic [STAT_WIDTH-1:0]           drop_count,
  output logic [STAT_WIDTH-1:0]           oversize_count
);

  localparam int STRB_W = C_AXIS_DATA_WIDTH / 8;
  localparam int WORD_W = C_AXIS_DATA_WIDTH + C_AXIS_TUSER_WIDTH + STRB_W + 1;
  localparam logic [DEPTH_BITS:0] PTR_ONE = {{DEPTH_BITS{1'b0}}, 1'b1};

  pvf_state_e            state_q, state_d;
  logic [DEPTH_BITS:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0]   commit_ptr_q, commit_ptr_d;
  logic [DEPTH_BITS:0]   rd_ptr_q, rd_ptr_d;
  logic                  drop_pend_q, drop_pend_d;
  logic                  out_valid_q;

  logic                  full;
  logic                  oversize;
  logic                  in_beat;
  logic                  pkt_drop;
  logic                  ram_we;
  logic                  out_load;
  logic [WORD_W-1:0]     rd_word;

  // Equal index bits with differing wrap bits means every slot is occupied.
  assign full = (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]) &&
                (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]);

  // Buffer holds nothing but the open packet: it can never commit, so drop it.
  assign oversize = (state_q == ACCEPT) && full && (commit_ptr_q == rd_ptr_q);

  assign s_axis_tready = (state_q == DISCARD) || !full || oversize;
  assign in_beat       = s_axis_tvalid && s_axis_tready;
  assign pkt_drop      = drop_pend_q || s_axis_tdrop;
  assign out_load      = (rd_ptr_q != commit_ptr_q) && (!out_valid_q || m_axis_tready);

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    drop_pend_d  = drop_pend_q;
    ram_we       = 1'b0;
    case (state_q)
      ACCEPT: begin
        if (oversize) begin
          wr_ptr_d    = commit_ptr_q;
          drop_pend_d = 1'b0;
          state_d     = (in_beat && s_axis_tlast) ? ACCEPT : DISCARD;
        end else if (in_beat) begin
          ram_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PTR_ONE;
          if (s_axis_tlast) begin
            drop_pend_d = 1'b0;
            if (pkt_drop) begin
              wr_ptr_d = commit_ptr_q;
            end else begin
              commit_ptr_d = wr_ptr_q + PTR_ONE;
            end
          end else begin
            drop_pend_d = pkt_drop;
          end
        end
      end
      DISCARD: begin
        if (in_beat && s_axis_tlast) begin
          state_d     = ACCEPT;
          drop_pend_d = 1'b0;
        end
      end
      default: begin
        state_d = ACCEPT;
      end
    endcase
  end

  assign rd_ptr_d = out_load ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state_q      <= ACCEPT;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      drop_pend_q  <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_pend_q  <= drop_pend_d;
      if (out_load) begin
        out_valid_q <= 1'b1;
      end else if (m_axis_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  pvf_sdp_ram #(
    .WIDTH      (WORD_W),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_ram (
    .clk_i   (axi_aclk),
    .rst_i   (axi_reset),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[DEPTH_BITS-1:0]),
    .wdata_i ({s_axis_tlast, s_axis_tstrb, s_axis_tuser, s_axis_tdata}),
    .re_i    (out_load),
    .raddr_i (rd_ptr_q[DEPTH_BITS-1:0]),
    .rdata_o (rd_word)
  );

  assign {m_axis_tlast, m_axis_tstrb, m_axis_tuser, m_axis_tdata} = rd_word;
  assign m_axis_tvalid = out_valid_q;

`ifdef PKT_VERDICT_STATS_EN
  logic                  accept_last;
  logic                  pass_ev;
  logic                  drop_ev;
  logic [STAT_WIDTH-1:0] pass_q;
  logic [STAT_WIDTH-1:0] drop_q;
  logic [STAT_WIDTH-1:0] ovs_q;

  assign accept_last = (state_q == ACCEPT) && !oversize && in_beat && s_axis_tlast;
  assign pass_ev     = accept_last && !pkt_drop;
  assign drop_ev     = oversize || (accept_last && pkt_drop);

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      pass_q <= '0;
      drop_q <= '0;
      ovs_q  <= '0;
    end else begin
      if (pass_ev)  pass_q <= sat_inc(pass_q);
      if (drop_ev)  drop_q <= sat_inc(drop_q);
      if (oversize) ovs_q  <= sat_inc(ovs_q);
    end
  end

  assign pass_count     = pass_q;
  assign drop_count     = drop_q;
  assign oversize_count = ovs_q;
`else
  assign pass_count     = '0;
  assign drop_count     = '0;
  assign oversize_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_packet_verdict_filter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_packet_verdict_filter : scoreboard bench for packet_verdict_filter       |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_packet_verdict_filter;

  localparam int DW    = 32;
  localparam int UW    = 8;
  localparam int SW    = DW / 8;
  localparam int DB    = 4;
  localparam int DEPTH = 1 << DB;
  localparam int TIMEOUT = 2000;

`ifdef PKT_VERDICT_STATS_EN
  localparam bit STATS_EN = 1'b1;
`else
  localparam bit STATS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic [UW-1:0] u;
    logic          l;
  } beat_t;

  logic          axi_aclk = 1'b0;
  logic          axi_reset;
  logic [DW-1:0] s_axis_tdata;
  logic [SW-1:0] s_axis_tstrb;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic          s_axis_tdrop;
  logic [DW-1:0] m_axis_tdata;
  logic [SW-1:0] m_axis_tstrb;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tlast;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [31:0]   pass_count;
  logic [31:0]   drop_count;
  logic [31:0]   oversize_count;

  packet_verdict_filter #(
    .C_AXIS_DATA_WIDTH  (DW),
    .C_AXIS_TUSER_WIDTH (UW),
    .DEPTH_BITS         (DB)
  ) dut (
    .axi_aclk       (axi_aclk),
    .axi_reset      (axi_reset),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tstrb   (s_axis_tstrb),
    .s_axis_tuser   (s_axis_tuser),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tdrop   (s_axis_tdrop),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tstrb   (m_axis_tstrb),
    .m_axis_tuser   (m_axis_tuser),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .pass_count     (pass_count),
    .drop_count     (drop_count),
    .oversize_count (oversize_count)
  );

  always #5 axi_aclk = ~axi_aclk;

  int    errors = 0;
  int    checks = 0;
  beat_t exp_q[$];
  int    m_pass = 0;
  int    m_drop = 0;
  int    m_ovs  = 0;
  int    stall_cnt = 0;
  int    rdy_mode = 0;   // 0: never ready, 1: always ready, 2: random

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Downstream ready changes just after each rising edge.
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge axi_aclk);
      #2;
      case (rdy_mode)
        0:       m_axis_tready = 1'b0;
        1:       m_axis_tready = 1'b1;
        default: m_axis_tready = ($urandom_range(0, 9) < 7);
      endcase
    end
  end

  // Monitor: pops the scoreboard on every output handshake, checks hold stability.
  initial begin
    bit    held;
    beat_t held_b;
    beat_t cur;
    beat_t exp;
    held = 1'b0;
    forever begin
      @(negedge axi_aclk);
      cur = '{d: m_axis_tdata, s: m_axis_tstrb, u: m_axis_tuser, l: m_axis_tlast};
      if (axi_reset) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_valid", {63'd0, m_axis_tvalid}, 64'd1);
          chk("hold_data", {19'd0, cur}, {19'd0, held_b});
        end
        if (m_axis_tvalid && m_axis_tready) begin
          held = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none", cur);
          end else begin
            exp = exp_q.pop_front();
            chk("out_beat", {19'd0, cur}, {19'd0, exp});
          end
        end else if (m_axis_tvalid) begin
          held   = 1'b1;
          held_b = cur;
        end else begin
          held = 1'b0;
        end
      end
    end
  end

  // All stimulus is applied at falling edges; tready depends only on DUT state.
  task automatic send_beat(input beat_t b, input bit dr);
    int guard;
    bit rdy;
    guard = 0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b.d;
    s_axis_tstrb  = b.s;
    s_axis_tuser  = b.u;
    s_axis_tlast  = b.l;
    s_axis_tdrop  = dr;
    forever begin
      rdy = s_axis_tready;
      if (!rdy) stall_cnt++;
      @(posedge axi_aclk);
      if (rdy) break;
      guard++;
      if (guard > TIMEOUT) begin
        checks++;
        errors++;
        $display("FAIL in_timeout: got tready=0 for %0d cycles expected 1", guard);
        break;
      end
      @(negedge axi_aclk);
    end
    @(negedge axi_aclk);
    s_axis_tvalid = 1'b0;
    s_axis_tdrop  = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Reference: a packet passes iff it fits the buffer and no beat was flagged.
  task automatic send_packet(input int len, input int drop_at, input bit rnd);
    beat_t pkt[$];
    bit    any_drop;
    any_drop = 1'b0;
    for (int i = 0; i < len; i++) begin
      beat_t       b;
      bit          dr;
      logic [31:0] r;
      b.d = $urandom;
      r   = $urandom;
      b.s = r[SW-1:0];
      b.u = r[SW+UW-1:SW];
      b.l = (i == len - 1);
      dr  = (i == drop_at) || (rnd && ($urandom_range(0, 11) == 0));
      any_drop |= dr;
      if (rnd) repeat ($urandom_range(0, 2)) @(negedge axi_aclk);
      send_beat(b, dr);
      pkt.push_back(b);
    end
    if (len > DEPTH) begin
      m_ovs++;
      m_drop++;
    end else if (any_drop) begin
      m_drop++;
    end else begin
      m_pass++;
      foreach (pkt[k]) exp_q.push_back(pkt[k]);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    rdy_mode = 1;
    while ((exp_q.size() != 0 || m_axis_tvalid) && g < TIMEOUT) begin
      @(negedge axi_aclk);
      g++;
    end
    repeat (4) @(negedge axi_aclk);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_pass"}, {32'd0, pass_count},     STATS_EN ? 64'(m_pass) : 64'd0);
    chk({tag, "_drop"}, {32'd0, drop_count},     STATS_EN ? 64'(m_drop) : 64'd0);
    chk({tag, "_ovs"},  {32'd0, oversize_count}, STATS_EN ? 64'(m_ovs)  : 64'd0);
  endtask

  initial begin
    beat_t b;
    axi_reset     = 1'b1;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tstrb  = '0;
    s_axis_tuser  = '0;
    s_axis_tlast  = 1'b0;
    s_axis_tdrop  = 1'b0;
    repeat (3) @(negedge axi_aclk);
    chk("rst_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("rst_mword", {19'd0, m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast}, 64'd0);
    chk_counters("rst");
    axi_reset = 1'b0;
    @(negedge axi_aclk);
    chk("rst_sready", {63'd0, s_axis_tready}, 64'd1);

    // Clean 3-beat packet and output latency.
    rdy_mode = 1;
    send_packet(3, -1, 1'b0);
    chk("lat_cycle1", {63'd0, m_axis_tvalid}, 64'd0);
    @(negedge axi_aclk);
    chk("lat_cycle2", {63'd0, m_axis_tvalid}, 64'd1);
    drain();

    // Flagged 4-beat packet, then clean 2-beat packet; then flagged 1-beat.
    send_packet(4, 1, 1'b0);
    send_packet(2, -1, 1'b0);
    send_packet(1, 0, 1'b0);
    drain();
    chk_counters("basic");

    // Oversize packet: must be swallowed without back-pressure.
    rdy_mode  = 0;
    stall_cnt = 0;
    send_packet(DEPTH + 4, -1, 1'b0);
    chk("ovs_stalls", 64'(stall_cnt), 64'd0);
    chk("ovs_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
    send_packet(2, -1, 1'b0);
    drain();
    chk_counters("ovs");

    // Two committed packets fill the buffer; the third must stall, then flow.
    rdy_mode = 0;
    send_packet(8, -1, 1'b0);
    send_packet(8, -1, 1'b0);
    fork
      send_packet(8, -1, 1'b0);
      begin
        repeat (30) @(negedge axi_aclk);
        chk("full_sready", {63'd0, s_axis_tready}, 64'd0);
        chk("full_mvalid", {63'd0, m_axis_tvalid}, 64'd1);
        rdy_mode = 1;
      end
    join
    drain();
    chk_counters("full");

    // Randomized traffic with random downstream back-pressure.
    rdy_mode = 2;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(DEPTH + 1, DEPTH + 4)
                                        : $urandom_range(1, DEPTH);
      send_packet(len, -1, 1'b1);
    end
    drain();
    chk_counters("rand");

    // Reset mid-packet discards the partial packet and clears everything.
    for (int i = 0; i < 2; i++) begin
      b = '{d: $urandom, s: '1, u: 8'h5A, l: 1'b0};
      send_beat(b, 1'b0);
    end
    axi_reset = 1'b1;
    @(negedge axi_aclk);
    m_pass = 0;
    m_drop = 0;
    m_ovs  = 0;
    chk("mrst_mvalid", {63'd0, m_axis_tvalid}, 64'd0);
    chk("mrst_mword", {19'd0, m_axis_tdata, m_axis_tstrb, m_axis_tuser, m_axis_tlast}, 64'd0);
    chk_counters("mrst");
    axi_reset = 1'b0;
    @(negedge axi_aclk);
    chk("mrst_sready", {63'd0, s_axis_tready}, 64'd1);
    send_packet(1, -1, 1'b0);
    drain();
    chk_counters("post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
